// File: rtl/add_sub_reservation_station.sv
// Reservation station for the add/sub unit: holds dispatched ops, snoops the CDB for
// missing operands and issues the lowest-index ready op each cycle.
package add_sub_pkg;
  typedef struct packed {
    logic sub;      // subtract (invert op1, carry-in handled by unit)
    logic use_ca;   // op consumes XER CA as carry-in
    logic set_ca;   // op writes XER CA
    logic set_ov;   // op writes XER OV
    logic rc;       // op writes CR0
  } add_sub_decode_t;
endpackage

module add_sub_reservation_station
  import add_sub_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
  input  logic [4:0]             dispatch_reg_addr,
  input  add_sub_decode_t        dispatch_control,
  input  logic [31:0]            dispatch_op1,
  input  logic [31:0]            dispatch_op2,
  input  logic                   dispatch_op1_valid,
  input  logic                   dispatch_op2_valid,
  input  logic                   dispatch_ca_valid,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
  input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
  input  logic [RS_ID_WIDTH-1:0] dispatch_ca_tag,
  input  logic                   dispatch_ca,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_ca,
  output logic                   issue_valid,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic                   issue_carry,
  output add_sub_decode_t        issue_control
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
    add_sub_decode_t        control;
    logic [31:0]            op1;
    logic                   op1_valid;
    logic [RS_ID_WIDTH-1:0] op1_tag;
    logic [31:0]            op2;
    logic                   op2_valid;
    logic [RS_ID_WIDTH-1:0] op2_tag;
    logic                   ca;
    logic                   ca_valid;
    logic [RS_ID_WIDTH-1:0] ca_tag;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   ready;
  logic               any_ready;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               dispatch_fire;
  entry_t             dsp;

  assign dispatch_ready = |(~busy);
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  always_comb begin
    ready     = '0;
    any_ready = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && ent[i].op1_valid && ent[i].op2_valid && ent[i].ca_valid;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  // Incoming entry, including same-edge capture from the CDB.
  always_comb begin
    dsp           = '0;
    dsp.rs_id     = dispatch_rs_id;
    dsp.reg_addr  = dispatch_reg_addr;
    dsp.control   = dispatch_control;
    dsp.op1       = dispatch_op1;
    dsp.op1_valid = dispatch_op1_valid;
    dsp.op1_tag   = dispatch_op1_tag;
    dsp.op2       = dispatch_op2;
    dsp.op2_valid = dispatch_op2_valid;
    dsp.op2_tag   = dispatch_op2_tag;
    dsp.ca        = dispatch_ca;
    dsp.ca_valid  = dispatch_ca_valid;
    dsp.ca_tag    = dispatch_ca_tag;
    if (!dispatch_control.use_ca) begin
      dsp.ca       = 1'b0;
      dsp.ca_valid = 1'b1;
    end
    if (cdb_valid) begin
      if (!dsp.op1_valid && dsp.op1_tag == cdb_rs_id) begin
        dsp.op1       = cdb_result;
        dsp.op1_valid = 1'b1;
      end
      if (!dsp.op2_valid && dsp.op2_tag == cdb_rs_id) begin
        dsp.op2       = cdb_result;
        dsp.op2_valid = 1'b1;
      end
      if (!dsp.ca_valid && dsp.ca_tag == cdb_rs_id) begin
        dsp.ca       = cdb_ca;
        dsp.ca_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      issue_valid    <= 1'b0;
      issue_rs_id    <= '0;
      issue_reg_addr <= '0;
      issue_op1      <= '0;
      issue_op2      <= '0;
      issue_carry    <= 1'b0;
      issue_control  <= '0;
    end else begin
      issue_valid <= any_ready;
      if (any_ready) begin
        issue_rs_id    <= ent[sel_idx].rs_id;
        issue_reg_addr <= ent[sel_idx].reg_addr;
        issue_op1      <= ent[sel_idx].op1;
        issue_op2      <= ent[sel_idx].op2;
        issue_carry    <= ent[sel_idx].ca;
        issue_control  <= ent[sel_idx].control;
      end
      // The issuing entry is busy and the dispatch target is free, so they never collide.
      for (int i = 0; i < DEPTH; i++) begin
        if (any_ready && sel_idx == IDX_W'(i)) busy[i] <= 1'b0;
        if (dispatch_fire && free_idx == IDX_W'(i)) busy[i] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: busy alone qualifies every entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && cdb_valid) begin
        if (!ent[i].op1_valid && ent[i].op1_tag == cdb_rs_id) begin
          ent[i].op1       <= cdb_result;
          ent[i].op1_valid <= 1'b1;
        end
        if (!ent[i].op2_valid && ent[i].op2_tag == cdb_rs_id) begin
          ent[i].op2       <= cdb_result;
          ent[i].op2_valid <= 1'b1;
        end
        if (!ent[i].ca_valid && ent[i].ca_tag == cdb_rs_id) begin
          ent[i].ca       <= cdb_ca;
          ent[i].ca_valid <= 1'b1;
        end
      end
      if (dispatch_fire && free_idx == IDX_W'(i)) ent[i] <= dsp;
    end
  end

endmodule

// File: tb/tb_add_sub_reservation_station.sv
// Directed bench for add_sub_reservation_station: stimulus pushes expected issues into a
// queue, a negedge monitor pops and compares every issued op.
module tb_add_sub_reservation_station;
  import add_sub_pkg::*;

  localparam add_sub_decode_t CTL_ADD  = '{sub:1'b0, use_ca:1'b0, set_ca:1'b0, set_ov:1'b0, rc:1'b0};
  localparam add_sub_decode_t CTL_ADDE = '{sub:1'b0, use_ca:1'b1, set_ca:1'b1, set_ov:1'b0, rc:1'b1};
  localparam add_sub_decode_t CTL_SUB  = '{sub:1'b1, use_ca:1'b0, set_ca:1'b1, set_ov:1'b1, rc:1'b0};

  logic clk = 1'b0;
  logic rst;
  logic dispatch_valid, dispatch_ready;
  logic [4:0] dispatch_rs_id, dispatch_reg_addr;
  add_sub_decode_t dispatch_control;
  logic [31:0] dispatch_op1, dispatch_op2;
  logic dispatch_op1_valid, dispatch_op2_valid, dispatch_ca_valid;
  logic [4:0] dispatch_op1_tag, dispatch_op2_tag, dispatch_ca_tag;
  logic dispatch_ca;
  logic cdb_valid;
  logic [4:0] cdb_rs_id;
  logic [31:0] cdb_result;
  logic cdb_ca;
  logic issue_valid;
  logic [4:0] issue_rs_id, issue_reg_addr;
  logic [31:0] issue_op1, issue_op2;
  logic issue_carry;
  add_sub_decode_t issue_control;

  add_sub_reservation_station #(.RS_ID_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs_id(dispatch_rs_id), .dispatch_reg_addr(dispatch_reg_addr),
    .dispatch_control(dispatch_control),
    .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
    .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op2_valid(dispatch_op2_valid),
    .dispatch_ca_valid(dispatch_ca_valid),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
    .dispatch_ca_tag(dispatch_ca_tag), .dispatch_ca(dispatch_ca),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .cdb_ca(cdb_ca),
    .issue_valid(issue_valid), .issue_rs_id(issue_rs_id), .issue_reg_addr(issue_reg_addr),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_carry(issue_carry),
    .issue_control(issue_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rs_id;
    logic [4:0]      reg_addr;
    logic [31:0]     op1;
    logic [31:0]     op2;
    logic            carry;
    add_sub_decode_t ctl;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got rs_id 0x%0h expected no issue", issue_rs_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_rs_id", issue_rs_id, e.rs_id);
        chk("issue_reg_addr", issue_reg_addr, e.reg_addr);
        chk("issue_op1", issue_op1, e.op1);
        chk("issue_op2", issue_op2, e.op2);
        chk("issue_carry", issue_carry, e.carry);
        chk("issue_control", issue_control, e.ctl);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nchk(input string nm, input logic e);
    @(negedge clk);
    chk(nm, issue_valid, e);
  endtask

  task automatic disp(input logic [4:0] id, input add_sub_decode_t c,
                      input logic [31:0] a, input logic av, input logic [4:0] at,
                      input logic [31:0] b, input logic bv, input logic [4:0] bt,
                      input logic ca, input logic cav, input logic [4:0] ct);
    dispatch_valid     = 1'b1;
    dispatch_rs_id     = id;
    dispatch_reg_addr  = id + 5'd1;
    dispatch_control   = c;
    dispatch_op1       = a;  dispatch_op1_valid = av; dispatch_op1_tag = at;
    dispatch_op2       = b;  dispatch_op2_valid = bv; dispatch_op2_tag = bt;
    dispatch_ca        = ca; dispatch_ca_valid  = cav; dispatch_ca_tag = ct;
  endtask

  task automatic expect_issue(input logic [4:0] id, input logic [31:0] a, input logic [31:0] b,
                              input logic carry, input add_sub_decode_t c);
    exp_t e;
    e.rs_id = id; e.reg_addr = id + 5'd1; e.op1 = a; e.op2 = b; e.carry = carry; e.ctl = c;
    exp_q.push_back(e);
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] r, input logic ca);
    cdb_valid = 1'b1; cdb_rs_id = t; cdb_result = r; cdb_ca = ca;
  endtask

  initial begin
    rst = 1'b1;
    dispatch_valid = 1'b0;
    disp(0, CTL_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0; cdb_ca = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_issue_valid", issue_valid, 1'b0);
    chk("reset_issue_op1", issue_op1, 32'h0);
    chk("reset_issue_rs_id", issue_rs_id, 5'h0);
    chk("reset_dispatch_ready", dispatch_ready, 1'b1);

    // 1: all operands ready at dispatch
    cyc();
    disp(2, CTL_ADD, 32'd5, 1, 0, 32'd3, 1, 0, 1'b0, 1, 0);
    expect_issue(2, 32'd5, 32'd3, 1'b0, CTL_ADD);
    cyc(); dispatch_valid = 1'b0;
    nchk("t1_not_early", 1'b0);
    cyc(); nchk("t1_issue", 1'b1);
    cyc(); nchk("t1_idle", 1'b0);

    // 2: op2 waits on tag 7
    cyc();
    disp(4, CTL_ADD, 32'h20, 1, 0, 32'h0, 0, 7, 1'b0, 1, 0);
    expect_issue(4, 32'h20, 32'h10, 1'b0, CTL_ADD);
    cyc(); dispatch_valid = 1'b0;
    nchk("t2_wait0", 1'b0);
    cyc(); nchk("t2_wait1", 1'b0);
    cyc(); nchk("t2_wait2", 1'b0);
    cdb(7, 32'h10, 1'b0);
    cyc(); cdb_valid = 1'b0;
    nchk("t2_cdb_edge", 1'b0);
    cyc(); nchk("t2_issue", 1'b1);
    cyc(); nchk("t2_idle", 1'b0);

    // 3: fill all entries waiting on tag 9
    for (int i = 0; i < 4; i++) begin
      disp(5'(10 + i), CTL_ADD, 32'h0, 0, 9, 32'(i), 1, 0, 1'b0, 1, 0);
      expect_issue(5'(10 + i), 32'h99, 32'(i), 1'b0, CTL_ADD);
      cyc();
    end
    dispatch_valid = 1'b0;
    @(negedge clk);
    chk("t3_full_ready", dispatch_ready, 1'b0);
    cyc();
    disp(20, CTL_ADD, 32'h1, 1, 0, 32'h2, 1, 0, 1'b0, 1, 0);
    cyc(); dispatch_valid = 1'b0;
    nchk("t3_full_ignored", 1'b0);
    cdb(9, 32'h99, 1'b0);
    cyc(); cdb_valid = 1'b0;
    nchk("t3_cdb_edge", 1'b0);
    chk("t3_ready_still_0", dispatch_ready, 1'b0);
    cyc(); nchk("t3_issue0", 1'b1);
    chk("t3_ready_after_issue", dispatch_ready, 1'b1);
    cyc(); nchk("t3_issue1", 1'b1);
    cyc(); nchk("t3_issue2", 1'b1);
    cyc(); nchk("t3_issue3", 1'b1);
    cyc(); nchk("t3_idle", 1'b0);

    // 4: same-cycle CDB bypass at dispatch
    cyc();
    disp(5, CTL_ADD, 32'h0, 0, 3, 32'h1, 1, 0, 1'b0, 1, 0);
    cdb(3, 32'hAA, 1'b0);
    expect_issue(5, 32'hAA, 32'h1, 1'b0, CTL_ADD);
    cyc(); dispatch_valid = 1'b0; cdb_valid = 1'b0;
    nchk("t4_not_early", 1'b0);
    cyc(); nchk("t4_issue", 1'b1);
    cyc(); nchk("t4_idle", 1'b0);

    // 5: entries 1,2 ready while dispatch and CDB hit in the same cycle
    disp(21, CTL_ADD, 32'h0, 0, 15, 32'h1, 1, 0, 1'b0, 1, 0);
    cyc();
    disp(22, CTL_ADD, 32'h100, 1, 0, 32'h0, 0, 16, 1'b0, 1, 0);
    cyc();
    disp(23, CTL_ADD, 32'h0, 0, 16, 32'h200, 1, 0, 1'b0, 1, 0);
    cyc(); dispatch_valid = 1'b0;
    expect_issue(22, 32'h100, 32'h55, 1'b0, CTL_ADD);
    expect_issue(23, 32'h55, 32'h200, 1'b0, CTL_ADD);
    expect_issue(24, 32'h66, 32'h2, 1'b0, CTL_ADD);
    expect_issue(21, 32'h77, 32'h1, 1'b0, CTL_ADD);
    cdb(16, 32'h55, 1'b0);
    cyc();
    disp(24, CTL_ADD, 32'h0, 0, 17, 32'h2, 1, 0, 1'b0, 1, 0);
    cdb(17, 32'h66, 1'b0);
    cyc(); dispatch_valid = 1'b0; cdb_valid = 1'b0;
    nchk("t5_issue_e1", 1'b1);
    cyc(); nchk("t5_issue_e2", 1'b1);
    cyc(); nchk("t5_issue_e3", 1'b1);
    cyc(); nchk("t5_idle", 1'b0);
    cdb(15, 32'h77, 1'b0);
    cyc(); cdb_valid = 1'b0;
    cyc(); nchk("t5_issue_e0", 1'b1);
    cyc(); nchk("t5_idle2", 1'b0);

    // 7: carry operand woken from CDB
    disp(30, CTL_ADDE, 32'h7, 1, 0, 32'h8, 1, 0, 1'b0, 0, 11);
    expect_issue(30, 32'h7, 32'h8, 1'b1, CTL_ADDE);
    cyc(); dispatch_valid = 1'b0;
    nchk("t7_wait", 1'b0);
    cdb(11, 32'hDEAD, 1'b1);
    cyc(); cdb_valid = 1'b0;
    nchk("t7_cdb_edge", 1'b0);
    cyc(); nchk("t7_issue", 1'b1);

    // 8: no carry-in selected, dispatch_ca/ca_valid ignored
    disp(31, CTL_SUB, 32'h1234, 1, 0, 32'h34, 1, 0, 1'b1, 0, 12);
    expect_issue(31, 32'h1234, 32'h34, 1'b0, CTL_SUB);
    cyc(); dispatch_valid = 1'b0;
    nchk("t8_not_early", 1'b0);
    cyc(); nchk("t8_issue", 1'b1);
    cyc(); nchk("t8_idle", 1'b0);

    // 6: reset discards waiting entries
    disp(1, CTL_ADD, 32'h0, 0, 25, 32'h3, 1, 0, 1'b0, 1, 0);
    cyc();
    disp(3, CTL_ADD, 32'h4, 1, 0, 32'h0, 0, 26, 1'b0, 1, 0);
    cyc(); dispatch_valid = 1'b0;
    rst = 1'b1;
    cyc(); rst = 1'b0;
    cdb(25, 32'h5, 1'b0);
    cyc();
    cdb(26, 32'h6, 1'b0);
    cyc(); cdb_valid = 1'b0;
    nchk("t6_no_issue0", 1'b0);
    chk("t6_ready", dispatch_ready, 1'b1);
    chk("t6_issue_op1_cleared", issue_op1, 32'h0);
    cyc(); nchk("t6_no_issue1", 1'b0);
    cyc(); nchk("t6_no_issue2", 1'b0);

    chk("all_expected_issued", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
